// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: address map, access
// op encodings and architectural bit positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_READ = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MIP_MTIP       = 7;
  localparam int MIP_MEIP       = 11;
  localparam int MCAUSE_IRQ     = 31;

  localparam logic [31:0] MIE_MASK = 32'h0000_0880;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with an increment enable and a per-half write
// port; any write that cycle replaces its half and suppresses the increment.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  always_comb begin
    // NOTE: count_d starts from count_q so every path assigns it and no latch is inferred.
    count_d = count_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) count_d[31:0]  = wdata_i;
      if (wr_hi_i) count_d[63:32] = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file for the RV32 core: atomic RW/RS/RC access, trap entry
// and MRET sequencing, 64-bit mcycle/minstret and registered interrupt pending.
module csr_file_m #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] VENDOR_ID   = 32'h0,
  parameter logic [31:0] ARCH_ID     = 32'h0,
  parameter logic [31:0] IMP_ID      = 32'h0,
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            csr_req_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic            csr_valid_o,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            instret_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  output logic            irq_pending_o,
  output logic [XLEN-1:0] trap_target_o,
  output logic [XLEN-1:0] mepc_o
);

  import csr_pkg::*;

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic            meip_q, mtip_q;
  logic            irq_pending_q, irq_pending_d;
  logic            csr_valid_q;
  logic [XLEN-1:0] csr_rdata_q, csr_rdata_d;
  logic            csr_illegal_q, csr_illegal_d;

  logic [63:0]     mcycle, minstret;
  logic [XLEN-1:0] mip_val, mstatus_val, rd_value, wr_value, trap_base;
  logic            rd_hit, wr_attempt, wr_en;
  csr_op_e         op;

  assign op = csr_op_e'(csr_op_i);

  always_comb begin
    mip_val = '0;
    mip_val[MIP_MEIP] = meip_q;
    mip_val[MIP_MTIP] = mtip_q;
    mstatus_val = '0;
    mstatus_val[MSTATUS_MPP_LO +: 2] = 2'b11;
    mstatus_val[MSTATUS_MIE]  = mstatus_mie_q;
    mstatus_val[MSTATUS_MPIE] = mstatus_mpie_q;
  end

  always_comb begin
    rd_hit   = 1'b1;
    rd_value = '0;
    case (csr_addr_i)
      CSR_MISA:      rd_value = MISA_VAL;
      CSR_MVENDORID: rd_value = VENDOR_ID;
      CSR_MARCHID:   rd_value = ARCH_ID;
      CSR_MIMPID:    rd_value = IMP_ID;
      CSR_MHARTID:   rd_value = HART_ID;
      CSR_MSTATUS:   rd_value = mstatus_val;
      CSR_MIE:       rd_value = mie_q;
      CSR_MTVEC:     rd_value = mtvec_q;
      CSR_MSCRATCH:  rd_value = mscratch_q;
      CSR_MEPC:      rd_value = mepc_q;
      CSR_MCAUSE:    rd_value = mcause_q;
      CSR_MIP:       rd_value = mip_val;
      CSR_MCYCLE:    rd_value = mcycle[31:0];
      CSR_MCYCLEH:   rd_value = mcycle[63:32];
      CSR_MINSTRET:  rd_value = minstret[31:0];
      CSR_MINSTRETH: rd_value = minstret[63:32];
      default:       rd_hit   = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      CSR_OP_RW: wr_value = csr_wdata_i;
      CSR_OP_RS: wr_value = rd_value | csr_wdata_i;
      CSR_OP_RC: wr_value = rd_value & ~csr_wdata_i;
      default:   wr_value = rd_value;
    endcase
    // Set/clear with a zero mask is a pure read and may target read-only space.
    wr_attempt    = (op == CSR_OP_RW) || ((op == CSR_OP_RS || op == CSR_OP_RC) && (|csr_wdata_i));
    csr_illegal_d = csr_req_i && (!rd_hit || (wr_attempt && csr_addr_i[11:10] == 2'b11));
    wr_en         = csr_req_i && wr_attempt && !csr_illegal_d && !trap_i && !mret_i;
    csr_rdata_d   = (csr_req_i && !csr_illegal_d) ? rd_value : '0;
    irq_pending_d = mstatus_mie_q && (|(mip_val & mie_q));
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    if (trap_i) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mepc_d         = {trap_pc_i[XLEN-1:2], 2'b00};
      mcause_d       = trap_cause_i;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wr_value[MSTATUS_MIE];
          mstatus_mpie_d = wr_value[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = wr_value & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = {wr_value[XLEN-1:2], wr_value[1] ? 2'b00 : wr_value[1:0]};
        CSR_MSCRATCH: mscratch_d = wr_value;
        CSR_MEPC:     mepc_d     = {wr_value[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wr_value;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      meip_q         <= 1'b0;
      mtip_q         <= 1'b0;
      irq_pending_q  <= 1'b0;
      csr_valid_q    <= 1'b0;
      csr_rdata_q    <= '0;
      csr_illegal_q  <= 1'b0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      meip_q         <= irq_ext_i;
      mtip_q         <= irq_timer_i;
      irq_pending_q  <= irq_pending_d;
      csr_valid_q    <= csr_req_i;
      csr_rdata_q    <= csr_rdata_d;
      csr_illegal_q  <= csr_illegal_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .wr_lo_i (wr_en && csr_addr_i == CSR_MCYCLE),
    .wr_hi_i (wr_en && csr_addr_i == CSR_MCYCLEH),
    .wdata_i (wr_value),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (instret_i),
    .wr_lo_i (wr_en && csr_addr_i == CSR_MINSTRET),
    .wr_hi_i (wr_en && csr_addr_i == CSR_MINSTRETH),
    .wdata_i (wr_value),
    .count_o (minstret)
  );

  always_comb begin
    trap_base     = {mtvec_q[XLEN-1:2], 2'b00};
    trap_target_o = trap_base;
    if (mtvec_q[1:0] == 2'b01 && trap_cause_i[MCAUSE_IRQ])
      trap_target_o = trap_base + {{(XLEN-7){1'b0}}, trap_cause_i[4:0], 2'b00};
  end

  assign csr_valid_o   = csr_valid_q;
  assign csr_rdata_o   = csr_rdata_q;
  assign csr_illegal_o = csr_illegal_q;
  assign irq_pending_o = irq_pending_q;
  assign mepc_o        = mepc_q;

endmodule

// File: tb/tb_csr_file_m.sv
// Self-checking bench for csr_file_m: directed vector table, hand-written
// trap/counter/interrupt sequences and randomized traffic against a reference model.
module tb_csr_file_m;

  logic        clk_i = 1'b0;
  logic        rst_i, csr_req_i, trap_i, mret_i, instret_i, irq_ext_i, irq_timer_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i, trap_cause_i, trap_pc_i;
  logic        csr_valid_o, csr_illegal_o, irq_pending_o;
  logic [31:0] csr_rdata_o, trap_target_o, mepc_o;

  always #5 clk_i = ~clk_i;

  csr_file_m dut (
    .clk_i(clk_i), .rst_i(rst_i), .csr_req_i(csr_req_i), .csr_op_i(csr_op_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_valid_o(csr_valid_o),
    .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o), .trap_i(trap_i),
    .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i), .mret_i(mret_i),
    .instret_i(instret_i), .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
    .irq_pending_o(irq_pending_o), .trap_target_o(trap_target_o), .mepc_o(mepc_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state held as plain values.
  bit          m_mstatus_mie, m_mstatus_mpie, m_meip, m_mtip, m_pend, m_valid, m_illegal;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_rdata;
  logic [63:0] m_cyc, m_ret;

  function automatic bit model_read(input logic [11:0] a, output logic [31:0] v);
    bit hit = 1'b1;
    case (a)
      12'h301: v = 32'h4000_0100;
      12'hF11, 12'hF12, 12'hF13, 12'hF14: v = 32'h0;
      12'h300: v = 32'h1800 | (m_mstatus_mie ? 32'h8 : 32'h0) | (m_mstatus_mpie ? 32'h80 : 32'h0);
      12'h304: v = m_mie_reg;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h344: v = (m_meip ? 32'h800 : 32'h0) | (m_mtip ? 32'h80 : 32'h0);
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ret[31:0];
      12'hB82: v = m_ret[63:32];
      default: begin v = 32'h0; hit = 1'b0; end
    endcase
    return hit;
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] cause);
    logic [31:0] base = m_mtvec & ~32'h3;
    if (m_mtvec[1:0] == 2'b01 && cause[31]) return base + 32'(cause[4:0]) * 32'd4;
    return base;
  endfunction

  task automatic step(input bit rst, input bit req, input logic [1:0] op, input logic [11:0] addr,
                      input logic [31:0] wdata, input bit trap, input logic [31:0] cause,
                      input logic [31:0] pc, input bit mret, input bit ins, input bit ext, input bit tmr);
    logic [31:0] old, nv;
    logic [63:0] cyc_n, ret_n;
    bit hit, wr, ill, do_wr;
    rst_i = rst; csr_req_i = req; csr_op_i = op; csr_addr_i = addr; csr_wdata_i = wdata;
    trap_i = trap; trap_cause_i = cause; trap_pc_i = pc; mret_i = mret; instret_i = ins;
    irq_ext_i = ext; irq_timer_i = tmr;
    if (rst) begin
      m_mstatus_mie = 0; m_mstatus_mpie = 0; m_meip = 0; m_mtip = 0; m_pend = 0;
      m_valid = 0; m_illegal = 0; m_rdata = 0; m_mie_reg = 0; m_mtvec = 32'h100;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ret = 0;
    end else begin
      hit   = model_read(addr, old);
      wr    = (op == 2'b01) || ((op == 2'b10 || op == 2'b11) && wdata != 32'h0);
      ill   = req && (!hit || (wr && addr[11:10] == 2'b11));
      m_valid = req; m_illegal = ill;
      m_rdata = (req && !ill) ? old : 32'h0;
      nv    = (op == 2'b01) ? wdata : (op == 2'b10) ? (old | wdata) : (old & ~wdata);
      do_wr = req && wr && !ill && !trap && !mret;
      m_pend = m_mstatus_mie && ((m_meip && m_mie_reg[11]) || (m_mtip && m_mie_reg[7]));
      m_meip = ext; m_mtip = tmr;
      cyc_n = m_cyc + 64'd1;
      ret_n = m_ret + 64'(ins);
      if (trap) begin
        m_mstatus_mpie = m_mstatus_mie; m_mstatus_mie = 0;
        m_mepc = pc & ~32'h3; m_mcause = cause;
      end else if (mret) begin
        m_mstatus_mie = m_mstatus_mpie; m_mstatus_mpie = 1;
      end else if (do_wr) begin
        case (addr)
          12'h300: begin m_mstatus_mie = nv[3]; m_mstatus_mpie = nv[7]; end
          12'h304: m_mie_reg = nv & 32'h880;
          12'h305: m_mtvec = nv[1] ? (nv & ~32'h3) : nv;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~32'h3;
          12'h342: m_mcause = nv;
          12'hB00: cyc_n = {m_cyc[63:32], nv};
          12'hB80: cyc_n = {nv, m_cyc[31:0]};
          12'hB02: ret_n = {m_ret[63:32], nv};
          12'hB82: ret_n = {nv, m_ret[31:0]};
          default: ;
        endcase
      end
      m_cyc = cyc_n; m_ret = ret_n;
    end
    @(posedge clk_i);
    #1;
    check("mdl_valid", 32'(csr_valid_o), 32'(m_valid));
    if (m_valid) begin
      check("mdl_rdata", csr_rdata_o, m_rdata);
      check("mdl_illegal", 32'(csr_illegal_o), 32'(m_illegal));
    end
    check("mdl_pending", 32'(irq_pending_o), 32'(m_pend));
    check("mdl_mepc", mepc_o, m_mepc);
    check("mdl_target", trap_target_o, model_target(cause));
  endtask

  bit irq_e = 0, irq_t = 0, ins_lvl = 0;

  task automatic acc(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
    step(0, 1, op, addr, wdata, 0, 32'h0, 32'h0, 0, ins_lvl, irq_e, irq_t);
  endtask

  task automatic idle();
    step(0, 0, 2'b00, 12'h0, 32'h0, 0, 32'h0, 32'h0, 0, ins_lvl, irq_e, irq_t);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_ill;
  } vec_t;

  vec_t vecs[18];

  logic [11:0] addrs[21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                             12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12,
                             12'hF13, 12'hF14, 12'h340, 12'h304, 12'h7C0, 12'h345, 12'hF15};
  logic [31:0] r_wd;

  initial begin
    vecs[0]  = '{2'b00, 12'h305, 32'h0,        32'h0000_0100, 1'b0};
    vecs[1]  = '{2'b00, 12'hF14, 32'h0,        32'h0,         1'b0};
    vecs[2]  = '{2'b01, 12'h340, 32'hDEADBEEF, 32'h0,         1'b0};
    vecs[3]  = '{2'b10, 12'h340, 32'h0000_00F0, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{2'b11, 12'h340, 32'h0000_000F, 32'hDEADBEFF, 1'b0};
    vecs[5]  = '{2'b00, 12'h340, 32'h0,        32'hDEADBEF0,  1'b0};
    vecs[6]  = '{2'b01, 12'hF11, 32'h1234,     32'h0,         1'b1};
    vecs[7]  = '{2'b00, 12'h7C0, 32'h0,        32'h0,         1'b1};
    vecs[8]  = '{2'b00, 12'hF11, 32'h0,        32'h0,         1'b0};
    vecs[9]  = '{2'b00, 12'h340, 32'h0,        32'hDEADBEF0,  1'b0};
    vecs[10] = '{2'b00, 12'h301, 32'h0,        32'h4000_0100, 1'b0};
    vecs[11] = '{2'b00, 12'h300, 32'h0,        32'h0000_1800, 1'b0};
    vecs[12] = '{2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0,        1'b0};
    vecs[13] = '{2'b00, 12'h304, 32'h0,        32'h0000_0880, 1'b0};
    vecs[14] = '{2'b01, 12'h305, 32'h0000_0103, 32'h0000_0100, 1'b0};
    vecs[15] = '{2'b00, 12'h305, 32'h0,        32'h0000_0100, 1'b0};
    vecs[16] = '{2'b01, 12'h341, 32'h0000_2003, 32'h0,        1'b0};
    vecs[17] = '{2'b00, 12'h341, 32'h0,        32'h0000_2000, 1'b0};

    repeat (3) step(1, 0, 2'b00, 12'h0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    check("rst_valid", 32'(csr_valid_o), 32'h0);
    check("rst_pending", 32'(irq_pending_o), 32'h0);
    check("rst_mepc", mepc_o, 32'h0);
    check("rst_target", trap_target_o, 32'h0000_0100);

    for (int i = 0; i < 18; i++) begin
      acc(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), csr_rdata_o, vecs[i].exp_rdata);
      check($sformatf("vec%0d_illegal", i), 32'(csr_illegal_o), 32'(vecs[i].exp_ill));
    end

    // Trap entry into a vectored handler, then MRET.
    acc(2'b01, 12'h300, 32'h8);
    acc(2'b01, 12'h305, 32'h201);
    step(0, 0, 2'b00, 12'h0, 32'h0, 1, 32'h8000_0007, 32'h1002, 0, 0, irq_e, irq_t);
    check("trap_target", trap_target_o, 32'h0000_021C);
    check("trap_mepc", mepc_o, 32'h0000_1000);
    acc(2'b00, 12'h300, 32'h0);
    check("trap_mstatus", csr_rdata_o, 32'h0000_1880);
    step(0, 0, 2'b00, 12'h0, 32'h0, 0, 32'h0, 32'h0, 1, 0, irq_e, irq_t);
    acc(2'b00, 12'h300, 32'h0);
    check("mret_mstatus", csr_rdata_o, 32'h0000_1888);

    // Carry from mcycle into mcycleh; a write suppresses that cycle's increment.
    acc(2'b01, 12'hB00, 32'hFFFF_FFFF);
    acc(2'b01, 12'hB80, 32'h0);
    idle();
    acc(2'b00, 12'hB80, 32'h0);
    check("mcycleh_carry", csr_rdata_o, 32'h1);
    acc(2'b01, 12'hB00, 32'h5);
    acc(2'b00, 12'hB00, 32'h0);
    check("mcycle_wr_noinc", csr_rdata_o, 32'h5);
    acc(2'b00, 12'hB00, 32'h0);
    check("mcycle_inc", csr_rdata_o, 32'h6);
    ins_lvl = 1;
    acc(2'b01, 12'hB02, 32'd10);
    acc(2'b00, 12'hB02, 32'h0);
    check("minstret_wr_noinc", csr_rdata_o, 32'd10);
    acc(2'b00, 12'hB02, 32'h0);
    check("minstret_inc", csr_rdata_o, 32'd11);
    ins_lvl = 0;

    // External interrupt: two-cycle input-to-pending latency, cleared by trap entry.
    acc(2'b01, 12'h304, 32'h800);
    irq_e = 1;
    idle();
    check("irq_lat1", 32'(irq_pending_o), 32'h0);
    idle();
    check("irq_lat2", 32'(irq_pending_o), 32'h1);
    acc(2'b00, 12'h344, 32'h0);
    check("mip_meip", csr_rdata_o, 32'h800);
    step(0, 0, 2'b00, 12'h0, 32'h0, 1, 32'h0000_000B, 32'h40, 0, 0, irq_e, irq_t);
    idle();
    check("irq_trap_clear", 32'(irq_pending_o), 32'h0);
    irq_e = 0;

    // CSR write coincident with a trap returns data but is dropped.
    step(0, 1, 2'b01, 12'h340, 32'h1234, 1, 32'h2, 32'h44, 0, 0, irq_e, irq_t);
    check("trapwr_rdata", csr_rdata_o, 32'hDEADBEF0);
    acc(2'b00, 12'h340, 32'h0);
    check("trapwr_dropped", csr_rdata_o, 32'hDEADBEF0);

    // Simultaneous trap and MRET: trap wins.
    acc(2'b01, 12'h300, 32'h80);
    step(0, 0, 2'b00, 12'h0, 32'h0, 1, 32'h3, 32'h3000, 1, 0, irq_e, irq_t);
    check("trapmret_mepc", mepc_o, 32'h3000);
    acc(2'b00, 12'h300, 32'h0);
    check("trapmret_mstatus", csr_rdata_o, 32'h0000_1800);

    // Reset in the middle of an access.
    step(1, 1, 2'b01, 12'h340, 32'h55, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    check("rst_mid_valid", 32'(csr_valid_o), 32'h0);
    acc(2'b00, 12'h340, 32'h0);
    check("rst_mid_lost", csr_rdata_o, 32'h0);

    for (int i = 0; i < 600; i++) begin
      r_wd = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      if ($urandom_range(0, 15) == 0) irq_e = ~irq_e;
      if ($urandom_range(0, 15) == 0) irq_t = ~irq_t;
      step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           addrs[$urandom_range(0, 20)], r_wd, $urandom_range(0, 15) == 0,
           {1'($urandom_range(0, 1)), 31'($urandom_range(0, 31))}, 32'($urandom),
           $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), irq_e, irq_t);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
